wb_port_arbiter: RTL and testbench

WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

---
 rtl/wb_port_arbiter.sv | 157 +++++++++++++++
 tb/tb_wb_port_arbiter.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter. The pipeline writeback stage and a
// multi-cycle unit (mul/div) share one write port. MDU results that lose
// arbitration wait in a 2-entry FIFO. A starvation counter stalls the
// pipeline for one cycle when the FIFO head keeps losing to pipeline writes.
module wb_port_arbiter #(
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        MEM_WB_regwrite,
    input  logic [4:0]  MEM_WB_rd,
    input  logic [31:0] MEM_WB_result,
    input  logic        mdu_valid,
    input  logic [4:0]  mdu_rd,
    input  logic [31:0] mdu_result,
    output logic        mdu_ready,
    output logic        pipe_stall,
    output logic [31:0] pending_mask,
    output logic        reg_write_enable,
    output logic [4:0]  reg_write_addr,
    output logic [31:0] reg_write_data
);

    localparam int CW = (STARVE_MAX > 1) ? $clog2(STARVE_MAX) : 1;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } entry_t;

    state_t          state, state_next;
    entry_t          fifo [2];
    entry_t          fifo_next [2];
    logic [CW-1:0]   starve_cnt, starve_cnt_next;
    logic            stall_next;
    logic [31:0]     mask_next;

    logic            head_valid;
    logic            mdu_xfer;
    logic            sel_head, sel_pipe, sel_mdu;
    logic            win_valid;
    logic [4:0]      win_rd;
    logic [31:0]     win_data;
    logic            pop, push;
    logic            wr_idx;
    logic [31:0]     push_bit, pop_bit;

    // MDU may hand over a result whenever a FIFO slot is free and not in reset.
    assign mdu_ready  = (state != FULL) && rst_n;
    assign mdu_xfer   = mdu_valid && mdu_ready;
    assign head_valid = (state != EMPTY);

    // Pick the single writer of the port this cycle and decide FIFO pop/push.
    always_comb begin
        // NOTE: every signal driven here gets a default first so no path leaves
        // it unassigned, which would otherwise infer a latch.
        sel_head = 1'b0;
        sel_pipe = 1'b0;
        sel_mdu  = 1'b0;
        if (pipe_stall && head_valid)
            sel_head = 1'b1;
        else if (MEM_WB_regwrite && !pipe_stall)
            sel_pipe = 1'b1;
        else if (head_valid)
            sel_head = 1'b1;
        else if (mdu_xfer)
            sel_mdu = 1'b1;

        win_valid = sel_head | sel_pipe | sel_mdu;
        win_rd    = fifo[0].rd;
        win_data  = fifo[0].data;
        if (sel_pipe) begin
            win_rd   = MEM_WB_rd;
            win_data = MEM_WB_result;
        end else if (sel_mdu) begin
            win_rd   = mdu_rd;
            win_data = mdu_result;
        end

        pop  = sel_head;
        // A losing MDU result is queued; r0 writes are meaningless and dropped.
        push = mdu_xfer && !sel_mdu && (mdu_rd != 5'd0);
    end

    // Next FIFO contents, occupancy, starvation counter and pending mask.
    always_comb begin
        fifo_next = fifo;
        // Tail slot after an optional pop: slot 1 only when one entry stays.
        wr_idx = (state == ONE) && !pop;
        if (pop)
            fifo_next[0] = fifo[1];
        if (push)
            fifo_next[wr_idx] = '{rd: mdu_rd, data: mdu_result};

        state_next = state;
        case ({push, pop})
            2'b10:   state_next = (state == EMPTY) ? ONE : FULL;
            2'b01:   state_next = (state == FULL) ? ONE : EMPTY;
            default: state_next = state;
        endcase

        stall_next      = 1'b0;
        starve_cnt_next = starve_cnt;
        if (!head_valid || pop) begin
            starve_cnt_next = '0;
        end else if (starve_cnt == CW'(STARVE_MAX - 1)) begin
            stall_next      = 1'b1;
            starve_cnt_next = '0;
        end else begin
            starve_cnt_next = starve_cnt + CW'(1);
        end

        push_bit  = push ? (32'd1 << mdu_rd) : 32'd0;
        pop_bit   = pop ? (32'd1 << fifo[0].rd) : 32'd0;
        // Set after clear so a same-register pop and push leaves the bit set.
        mask_next = (pending_mask & ~pop_bit) | push_bit;
    end

    // Control state and registered outputs.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples values from before this edge.
        if (!rst_n) begin
            state            <= EMPTY;
            starve_cnt       <= '0;
            pending_mask     <= '0;
            pipe_stall       <= 1'b0;
            reg_write_enable <= 1'b0;
            reg_write_addr   <= '0;
            reg_write_data   <= '0;
        end else begin
            state        <= state_next;
            starve_cnt   <= starve_cnt_next;
            pending_mask <= mask_next;
            pipe_stall   <= stall_next;
            reg_write_enable <= win_valid && (win_rd != 5'd0);
            if (win_valid) begin
                reg_write_addr <= win_rd;
                reg_write_data <= win_data;
            end
        end
    end

    // FIFO payload storage.
    always_ff @(posedge clk) begin
        // NOTE: payload slots are not reset; an EMPTY state makes their
        // contents irrelevant, which is also how reset discards queued writes.
        fifo <= fifo_next;
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: a vector table for single-cycle
// behaviour, hand-written sequences for buffering/starvation/reset, and a
// write-order scoreboard fed as stimulus is driven.
module tb_wb_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        MEM_WB_regwrite;
    logic [4:0]  MEM_WB_rd;
    logic [31:0] MEM_WB_result;
    logic        mdu_valid;
    logic [4:0]  mdu_rd;
    logic [31:0] mdu_result;
    logic        mdu_ready;
    logic        pipe_stall;
    logic [31:0] pending_mask;
    logic        reg_write_enable;
    logic [4:0]  reg_write_addr;
    logic [31:0] reg_write_data;

    always #5 clk = ~clk;

    wb_port_arbiter #(.STARVE_MAX(4)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .MEM_WB_regwrite  (MEM_WB_regwrite),
        .MEM_WB_rd        (MEM_WB_rd),
        .MEM_WB_result    (MEM_WB_result),
        .mdu_valid        (mdu_valid),
        .mdu_rd           (mdu_rd),
        .mdu_result       (mdu_result),
        .mdu_ready        (mdu_ready),
        .pipe_stall       (pipe_stall),
        .pending_mask     (pending_mask),
        .reg_write_enable (reg_write_enable),
        .reg_write_addr   (reg_write_addr),
        .reg_write_data   (reg_write_data)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } wr_t;

    wr_t pipe_q[$];
    wr_t mdu_q[$];

    typedef struct {
        logic        regwrite;
        logic [4:0]  rd;
        logic [31:0] result;
        logic        mvalid;
        logic [4:0]  mrd;
        logic [31:0] mresult;
        int          src;       // 0 none, 1 pipeline, 2 mdu (scoreboard feed)
        logic        exp_en;
        logic [4:0]  exp_addr;
        logic [31:0] exp_data;
        logic [31:0] exp_mask;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        MEM_WB_regwrite = 1'b0;
        MEM_WB_rd       = 5'd0;
        MEM_WB_result   = 32'd0;
        mdu_valid       = 1'b0;
        mdu_rd          = 5'd0;
        mdu_result      = 32'd0;
    endtask

    task automatic drive_pipe(input logic [4:0] rd, input logic [31:0] data);
        MEM_WB_regwrite = 1'b1;
        MEM_WB_rd       = rd;
        MEM_WB_result   = data;
    endtask

    task automatic drive_mdu(input logic [4:0] rd, input logic [31:0] data);
        mdu_valid  = 1'b1;
        mdu_rd     = rd;
        mdu_result = data;
    endtask

    task automatic sb_pipe(input logic [4:0] rd, input logic [31:0] data);
        wr_t e;
        e.rd = rd;
        e.data = data;
        pipe_q.push_back(e);
    endtask

    task automatic sb_mdu(input logic [4:0] rd, input logic [31:0] data);
        wr_t e;
        e.rd = rd;
        e.data = data;
        mdu_q.push_back(e);
    endtask

    // Advance one clock; outputs are examined 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every enabled write must be the next one of either stream.
    always @(negedge clk) begin
        if (reg_write_enable === 1'b1) begin
            if (mdu_q.size() != 0 && mdu_q[0].rd == reg_write_addr &&
                mdu_q[0].data == reg_write_data) begin
                checks++;
                void'(mdu_q.pop_front());
            end else if (pipe_q.size() != 0) begin
                wr_t e;
                e = pipe_q.pop_front();
                check("sb_write_addr", 32'(reg_write_addr), 32'(e.rd));
                check("sb_write_data", reg_write_data, e.data);
            end else begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected_write: got r%0d=0x%08h expected no write",
                         reg_write_addr, reg_write_data);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  pidx;
        int  midx;
        int  cyc;
        logic was_stall;
        logic xfer;
        logic wait_seen;
        logic [31:0] exp_stall [8];

        // regwrite rd result mvalid mrd mresult src en addr data mask
        vecs[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0, 32'h0,         1, 1'b1, 5'd5,  32'hDEADBEEF, 32'h0};
        vecs[1] = '{1'b1, 5'd0,  32'h12345678, 1'b0, 5'd0, 32'h0,         0, 1'b0, 5'd0,  32'h12345678, 32'h0};
        vecs[2] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd9, 32'hB0000009,  2, 1'b1, 5'd9,  32'hB0000009, 32'h0};
        vecs[3] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0, 32'hB0000000,  0, 1'b0, 5'd0,  32'hB0000000, 32'h0};
        vecs[4] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 32'h0,         0, 1'b0, 5'd0,  32'hB0000000, 32'h0};
        vecs[5] = '{1'b1, 5'd31, 32'hA000001F, 1'b0, 5'd0, 32'h0,         1, 1'b1, 5'd31, 32'hA000001F, 32'h0};
        vecs[6] = '{1'b1, 5'd2,  32'hA0000002, 1'b1, 5'd0, 32'hB0000077,  1, 1'b1, 5'd2,  32'hA0000002, 32'h0};
        vecs[7] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 32'h0,         0, 1'b0, 5'd2,  32'hA0000002, 32'h0};

        // ---------------- reset state ----------------
        rst_n = 1'b0;
        idle_inputs();
        step();
        step();
        check("rst_enable", 32'(reg_write_enable), 32'd0);
        check("rst_addr",   32'(reg_write_addr),   32'd0);
        check("rst_data",   reg_write_data,        32'd0);
        check("rst_mask",   pending_mask,          32'd0);
        check("rst_stall",  32'(pipe_stall),       32'd0);
        check("rst_ready",  32'(mdu_ready),        32'd0);

        // ---------------- vector table (first vector on release edge) ------
        rst_n = 1'b1;
        #1;
        check("release_ready", 32'(mdu_ready), 32'd1);
        for (int i = 0; i < 8; i++) begin
            MEM_WB_regwrite = vecs[i].regwrite;
            MEM_WB_rd       = vecs[i].rd;
            MEM_WB_result   = vecs[i].result;
            mdu_valid       = vecs[i].mvalid;
            mdu_rd          = vecs[i].mrd;
            mdu_result      = vecs[i].mresult;
            if (vecs[i].src == 1) sb_pipe(vecs[i].rd, vecs[i].result);
            if (vecs[i].src == 2) sb_mdu(vecs[i].mrd, vecs[i].mresult);
            step();
            check($sformatf("vec%0d_enable", i), 32'(reg_write_enable), 32'(vecs[i].exp_en));
            check($sformatf("vec%0d_addr", i),   32'(reg_write_addr),   32'(vecs[i].exp_addr));
            check($sformatf("vec%0d_data", i),   reg_write_data,        vecs[i].exp_data);
            check($sformatf("vec%0d_mask", i),   pending_mask,          vecs[i].exp_mask);
            check($sformatf("vec%0d_ready", i),  32'(mdu_ready),        32'd1);
        end
        idle_inputs();

        // ---------------- collision: pipeline r3 vs MDU r7 ----------------
        drive_pipe(5'd3, 32'hA0000003);
        drive_mdu(5'd7, 32'h00000011);
        sb_pipe(5'd3, 32'hA0000003);
        sb_mdu(5'd7, 32'h00000011);
        step();
        idle_inputs();
        check("coll_addr_r3", 32'(reg_write_addr), 32'd3);
        check("coll_mask",    pending_mask,        32'h00000080);
        step();
        check("coll_drain_en",   32'(reg_write_enable), 32'd1);
        check("coll_drain_addr", 32'(reg_write_addr),   32'd7);
        check("coll_drain_data", reg_write_data,        32'h00000011);
        check("coll_drain_mask", pending_mask,          32'd0);
        step();
        check("coll_idle_en", 32'(reg_write_enable), 32'd0);

        // ---------------- pop r4 while pushing r6 in ONE ----------------
        drive_pipe(5'd1, 32'hA0000001);
        drive_mdu(5'd4, 32'h00000044);
        sb_pipe(5'd1, 32'hA0000001);
        sb_mdu(5'd4, 32'h00000044);
        step();
        check("pp_mask_r4", pending_mask, 32'h00000010);
        idle_inputs();
        drive_mdu(5'd6, 32'h00000066);
        sb_mdu(5'd6, 32'h00000066);
        step();
        idle_inputs();
        check("pp_addr_r4", 32'(reg_write_addr), 32'd4);
        check("pp_mask_r6", pending_mask,        32'h00000040);
        check("pp_ready",   32'(mdu_ready),      32'd1);
        step();
        check("pp_addr_r6", 32'(reg_write_addr), 32'd6);
        check("pp_mask_0",  pending_mask,        32'd0);
        step();

        // ---------------- starvation with STARVE_MAX=4 ----------------
        exp_stall = '{0, 0, 0, 0, 1, 0, 0, 0};
        pidx = 0;
        drive_pipe(5'd20, 32'hA0000014);
        sb_pipe(5'd20, 32'hA0000014);
        drive_mdu(5'd12, 32'h12121212);
        sb_mdu(5'd12, 32'h12121212);
        for (int e = 0; e < 8; e++) begin
            was_stall = pipe_stall;
            step();
            mdu_valid = 1'b0;
            check($sformatf("starve_stall_e%0d", e), 32'(pipe_stall), exp_stall[e]);
            if (e == 5) check("starve_head_write", 32'(reg_write_addr), 32'd12);
            if (e == 6) check("starve_held_write", 32'(reg_write_addr), 32'd25);
            if (!was_stall) begin
                pidx++;
                if (pidx < 7) begin
                    drive_pipe(5'(20 + pidx), 32'hA0000014 + 32'(pidx));
                    sb_pipe(5'(20 + pidx), 32'hA0000014 + 32'(pidx));
                end else begin
                    MEM_WB_regwrite = 1'b0;
                end
            end
        end
        idle_inputs();
        step();
        step();

        // ---------------- full buffer under continuous pipeline writes ------
        pidx = 0;
        midx = 0;
        wait_seen = 1'b0;
        drive_pipe(5'd16, 32'hA1000000);
        sb_pipe(5'd16, 32'hA1000000);
        drive_mdu(5'd8, 32'h00008888);
        cyc = 0;
        while ((pidx < 12 || midx < 3) && cyc < 60) begin
            was_stall = pipe_stall;
            xfer = mdu_valid && mdu_ready;
            if (mdu_valid && !mdu_ready) wait_seen = 1'b1;
            if (xfer) sb_mdu(mdu_rd, mdu_result);
            step();
            cyc++;
            if (xfer) begin
                midx++;
                if (midx == 2) check("full_ready_low", 32'(mdu_ready), 32'd0);
                case (midx)
                    1: drive_mdu(5'd9,  32'h00009999);
                    2: drive_mdu(5'd10, 32'h0000AAAA);
                    default: mdu_valid = 1'b0;
                endcase
            end
            if (!was_stall && pidx < 12) begin
                pidx++;
                if (pidx < 12) begin
                    drive_pipe(5'(16 + (pidx % 8)), 32'hA1000000 + 32'(pidx));
                    sb_pipe(5'(16 + (pidx % 8)), 32'hA1000000 + 32'(pidx));
                end else begin
                    MEM_WB_regwrite = 1'b0;
                end
            end
        end
        check("full_stream_done", 32'(cyc < 60), 32'd1);
        check("full_mdu_waited",  32'(wait_seen), 32'd1);
        idle_inputs();
        cyc = 0;
        while ((pipe_q.size() != 0 || mdu_q.size() != 0) && cyc < 20) begin
            step();
            cyc++;
        end
        step();
        check("full_drain_pipe", 32'(pipe_q.size()), 32'd0);
        check("full_drain_mdu",  32'(mdu_q.size()),  32'd0);

        // ---------------- reset with a FULL buffer ----------------
        drive_pipe(5'd1, 32'hA2000001);
        sb_pipe(5'd1, 32'hA2000001);
        drive_mdu(5'd8, 32'h00000808);
        step();
        drive_pipe(5'd2, 32'hA2000002);
        sb_pipe(5'd2, 32'hA2000002);
        drive_mdu(5'd9, 32'h00000909);
        step();
        check("rfull_ready_low", 32'(mdu_ready),  32'd0);
        check("rfull_mask",      pending_mask,    32'h00000300);
        idle_inputs();
        rst_n = 1'b0;
        #1;
        check("rfull_ready_in_rst", 32'(mdu_ready), 32'd0);
        step();
        check("rfull_enable", 32'(reg_write_enable), 32'd0);
        check("rfull_addr",   32'(reg_write_addr),   32'd0);
        check("rfull_data",   reg_write_data,        32'd0);
        check("rfull_mask0",  pending_mask,          32'd0);
        check("rfull_stall",  32'(pipe_stall),       32'd0);
        rst_n = 1'b1;
        #1;
        check("rfull_ready_after", 32'(mdu_ready), 32'd1);
        for (int i = 0; i < 8; i++) step();
        check("rfull_no_writes", 32'(reg_write_enable), 32'd0);
        check("end_pipe_q", 32'(pipe_q.size()), 32'd0);
        check("end_mdu_q",  32'(mdu_q.size()),  32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
